// File: rtl/accfifo_pkg.sv
// Shared definitions for the ping-pong accumulate FIFO: default geometry
// and the swap-controller state encoding.
package accfifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 24;
    localparam int DEFAULT_DEPTH      = 32;

    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

endpackage

// File: rtl/acc_fifo_bank.sv
// One FIFO bank: DEPTH-word storage, read/write pointers and occupancy count.
// The read data register only updates on an accepted pop, so a caller can
// tell fresh data from stale data by remembering when it popped.
module acc_fifo_bank
    import accfifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] q,
    output logic [CNT_W-1:0]      count,
    output logic                  rd_ok
);
    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] q_reg;
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic                  wr_ok;

    // A pop needs data; a push needs room, or a same-cycle pop freeing a slot.
    assign rd_ok = rd && (count_reg != '0);
    assign wr_ok = wr && ((count_reg != FULL_COUNT) || rd_ok);

    // Storage with registered read; no reset so it maps onto RAM. At full with
    // pop+push both pointers match and the read returns the old word.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= din;
        end
        if (rd_ok) begin
            q_reg <= mem[rd_ptr_reg];
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign q     = q_reg;
    assign count = count_reg;

endmodule

// File: rtl/acc_fifo_pingpong.sv
// Ping-pong accumulate FIFO: two banks, one owned by the compute side
// (push/pop/read-modify-write) and one drained by the output side. A level
// swap request exchanges the roles once the output bank has drained.
// Optional build macro ACCFIFO_ERR_CHECK_EN adds a sticky err output for
// ignored pushes at full and pops on empty.
module acc_fifo_pingpong
    import accfifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] cmp_din,
    input  logic                  cmp_wr,
    input  logic                  cmp_rd,
    input  logic                  out_rd,
    input  logic                  swap_req,
    output logic [DATA_WIDTH-1:0] cmp_dout,
    output logic [DATA_WIDTH-1:0] out_dout,
    output logic                  out_valid,
    output logic                  cmp_full,
    output logic                  cmp_empty,
    output logic                  out_empty,
    output logic [CNT_W-1:0]      cmp_count,
    output logic [CNT_W-1:0]      out_count,
    output logic                  bank_sel,
    output logic                  swap_ack
`ifdef ACCFIFO_ERR_CHECK_EN
    ,
    output logic                  err
`endif
);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [1:0]            bank_wr;
    logic [1:0]            bank_rd;
    logic [1:0]            bank_rd_ok;
    logic [DATA_WIDTH-1:0] bank_q     [2];
    logic [CNT_W-1:0]      bank_count [2];

    logic        bank_sel_reg;
    logic        out_idx;
    logic        swap_ack_reg;
    logic        swap_do;
    swap_state_t state_reg;
    swap_state_t state_next;

    logic                  cmp_pop;
    logic                  out_pop;
    logic                  cmp_fresh_reg;
    logic                  cmp_src_reg;
    logic [DATA_WIDTH-1:0] cmp_hold_reg;
    logic                  out_fresh_reg;
    logic                  out_src_reg;
    logic [DATA_WIDTH-1:0] out_hold_reg;

    assign out_idx = ~bank_sel_reg;

    // Route each side's strobes to whichever bank it currently owns.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_wr[gi] = (bank_sel_reg == 1'(gi)) && cmp_wr;
            assign bank_rd[gi] = (bank_sel_reg == 1'(gi)) ? cmp_rd : out_rd;

            acc_fifo_bank #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (DEPTH),
                .CNT_W      (CNT_W)
            ) u_bank (
                .clk   (clk),
                .rst   (rst),
                .wr    (bank_wr[gi]),
                .rd    (bank_rd[gi]),
                .din   (cmp_din),
                .q     (bank_q[gi]),
                .count (bank_count[gi]),
                .rd_ok (bank_rd_ok[gi])
            );
        end
    endgenerate

    assign cmp_count = bank_count[bank_sel_reg];
    assign out_count = bank_count[out_idx];
    assign cmp_full  = (cmp_count == FULL_COUNT);
    assign cmp_empty = (cmp_count == '0);
    assign out_empty = (out_count == '0);
    assign cmp_pop   = bank_rd_ok[bank_sel_reg];
    assign out_pop   = bank_rd_ok[out_idx];

    // Swap controller: swap at once if the output bank is already drained,
    // otherwise wait in PENDING until it is.
    always_comb begin
        state_next = state_reg;
        swap_do    = 1'b0;
        case (state_reg)
            SWAP_IDLE: begin
                if (swap_req) begin
                    if (out_empty) begin
                        swap_do = 1'b1;
                    end else begin
                        state_next = SWAP_PENDING;
                    end
                end
            end
            SWAP_PENDING: begin
                if (out_empty) begin
                    swap_do    = 1'b1;
                    state_next = SWAP_IDLE;
                end
            end
        endcase
    end

    // Swap state, bank ownership and the one-cycle acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= SWAP_IDLE;
            bank_sel_reg <= 1'b0;
            swap_ack_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bank_sel_reg <= bank_sel_reg ^ swap_do;
            swap_ack_reg <= swap_do;
        end
    end

    // Output data: in the cycle after a pop show the popping bank's fresh read
    // register, then keep a private copy so a later swap or pop by the other
    // side cannot disturb the held value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_fresh_reg <= 1'b0;
            cmp_src_reg   <= 1'b0;
            cmp_hold_reg  <= '0;
            out_fresh_reg <= 1'b0;
            out_src_reg   <= 1'b0;
            out_hold_reg  <= '0;
        end else begin
            cmp_fresh_reg <= cmp_pop;
            if (cmp_pop) begin
                cmp_src_reg <= bank_sel_reg;
            end
            if (cmp_fresh_reg) begin
                cmp_hold_reg <= bank_q[cmp_src_reg];
            end
            out_fresh_reg <= out_pop;
            if (out_pop) begin
                out_src_reg <= out_idx;
            end
            if (out_fresh_reg) begin
                out_hold_reg <= bank_q[out_src_reg];
            end
        end
    end

    assign cmp_dout  = cmp_fresh_reg ? bank_q[cmp_src_reg] : cmp_hold_reg;
    assign out_dout  = out_fresh_reg ? bank_q[out_src_reg] : out_hold_reg;
    assign out_valid = out_fresh_reg;
    assign bank_sel  = bank_sel_reg;
    assign swap_ack  = swap_ack_reg;

`ifdef ACCFIFO_ERR_CHECK_EN
    logic err_reg;

    // Sticky flag for any strobe the banks had to ignore.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if ((cmp_wr && cmp_full && !cmp_rd) ||
                     (cmp_rd && cmp_empty) ||
                     (out_rd && out_empty)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: tb/tb_acc_fifo_pingpong.sv
// Self-checking bench for acc_fifo_pingpong: a table of directed vectors,
// hand-written swap/full sequences, and a randomized run against a
// queue-based reference model. err is checked when ACCFIFO_ERR_CHECK_EN is set.
module tb_acc_fifo_pingpong;

    localparam int DW    = 24;
    localparam int DEPTH = 32;
    localparam int CW    = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] cmp_din = '0;
    logic          cmp_wr = 1'b0;
    logic          cmp_rd = 1'b0;
    logic          out_rd = 1'b0;
    logic          swap_req = 1'b0;
    logic [DW-1:0] cmp_dout;
    logic [DW-1:0] out_dout;
    logic          out_valid;
    logic          cmp_full;
    logic          cmp_empty;
    logic          out_empty;
    logic [CW-1:0] cmp_count;
    logic [CW-1:0] out_count;
    logic          bank_sel;
    logic          swap_ack;
`ifdef ACCFIFO_ERR_CHECK_EN
    logic          err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    acc_fifo_pingpong #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmp_din   (cmp_din),
        .cmp_wr    (cmp_wr),
        .cmp_rd    (cmp_rd),
        .out_rd    (out_rd),
        .swap_req  (swap_req),
        .cmp_dout  (cmp_dout),
        .out_dout  (out_dout),
        .out_valid (out_valid),
        .cmp_full  (cmp_full),
        .cmp_empty (cmp_empty),
        .out_empty (out_empty),
        .cmp_count (cmp_count),
        .out_count (out_count),
        .bank_sel  (bank_sel),
        .swap_ack  (swap_ack)
`ifdef ACCFIFO_ERR_CHECK_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1);
    end

    // ---------------- reference model (queues, compute/output view) ----------
    logic [DW-1:0] cq[$];
    logic [DW-1:0] oq[$];
    bit            m_sel, m_pend, m_ack, m_ov, m_err;
    logic [DW-1:0] m_cdout, m_odout;

    task automatic model_reset();
        cq.delete();
        oq.delete();
        m_sel = 0; m_pend = 0; m_ack = 0; m_ov = 0; m_err = 0;
        m_cdout = '0; m_odout = '0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit c_pop, c_push, o_pop, o_empty, swap;
        logic [DW-1:0] tmp[$];
        o_empty = (oq.size() == 0);
        c_pop   = cmp_rd && (cq.size() != 0);
        c_push  = cmp_wr && ((cq.size() < DEPTH) || c_pop);
        o_pop   = out_rd && !o_empty;
        swap    = o_empty && (m_pend || swap_req);
        if ((cmp_wr && !c_push) || (cmp_rd && !c_pop) || (out_rd && !o_pop)) m_err = 1;
        m_pend = !swap && (m_pend || swap_req);
        if (c_pop)  m_cdout = cq.pop_front();
        if (c_push) cq.push_back(cmp_din);
        m_ov = o_pop;
        if (o_pop)  m_odout = oq.pop_front();
        m_ack = swap;
        if (swap) begin
            tmp = cq; cq = oq; oq = tmp;
            m_sel = !m_sel;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        check("cmp_dout",  32'(cmp_dout),  32'(m_cdout));
        check("out_dout",  32'(out_dout),  32'(m_odout));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("cmp_count", 32'(cmp_count), 32'(cq.size()));
        check("out_count", 32'(out_count), 32'(oq.size()));
        check("cmp_full",  32'(cmp_full),  32'(cq.size() == DEPTH));
        check("cmp_empty", 32'(cmp_empty), 32'(cq.size() == 0));
        check("out_empty", 32'(out_empty), 32'(oq.size() == 0));
        check("bank_sel",  32'(bank_sel),  32'(m_sel));
        check("swap_ack",  32'(swap_ack),  32'(m_ack));
`ifdef ACCFIFO_ERR_CHECK_EN
        check("err",       32'(err),       32'(m_err));
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " cmp_count"}, 32'(cmp_count), 32'd0);
        check({tag, " out_count"}, 32'(out_count), 32'd0);
        check({tag, " cmp_empty"}, 32'(cmp_empty), 32'd1);
        check({tag, " out_empty"}, 32'(out_empty), 32'd1);
        check({tag, " cmp_full"},  32'(cmp_full),  32'd0);
        check({tag, " bank_sel"},  32'(bank_sel),  32'd0);
        check({tag, " swap_ack"},  32'(swap_ack),  32'd0);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " cmp_dout"},  32'(cmp_dout),  32'd0);
        check({tag, " out_dout"},  32'(out_dout),  32'd0);
`ifdef ACCFIFO_ERR_CHECK_EN
        check({tag, " err"},       32'(err),       32'd0);
`endif
    endtask

    task automatic idle_inputs();
        cmp_wr = 0; cmp_rd = 0; out_rd = 0; swap_req = 0; cmp_din = '0;
    endtask

    // Advance one clock; return just after the edge so outputs are settled.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------------------------
    typedef struct {
        logic          wr, rd, ord, swp;
        logic [DW-1:0] din;
        logic [DW-1:0] e_cdout;
        int            e_ccnt, e_ocnt;
        logic          e_sel, e_ack, e_ov;
        logic [DW-1:0] e_odout;
    } vec_t;

    vec_t vecs[19];

    initial begin
        // push 3, pop 3, then fill 5 and swap, then drain the output bank
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0, 24'h10,  24'h00, 1,0, 1'b0,1'b0,1'b0, 24'h0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0, 24'h20,  24'h00, 2,0, 1'b0,1'b0,1'b0, 24'h0};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b0, 24'h30,  24'h00, 3,0, 1'b0,1'b0,1'b0, 24'h0};
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b0, 24'h0,   24'h10, 2,0, 1'b0,1'b0,1'b0, 24'h0};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0, 24'h0,   24'h20, 1,0, 1'b0,1'b0,1'b0, 24'h0};
        vecs[5]  = '{1'b0,1'b1,1'b0,1'b0, 24'h0,   24'h30, 0,0, 1'b0,1'b0,1'b0, 24'h0};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0, 24'h0,   24'h30, 0,0, 1'b0,1'b0,1'b0, 24'h0};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0, 24'h101, 24'h30, 1,0, 1'b0,1'b0,1'b0, 24'h0};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b0, 24'h102, 24'h30, 2,0, 1'b0,1'b0,1'b0, 24'h0};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b0, 24'h103, 24'h30, 3,0, 1'b0,1'b0,1'b0, 24'h0};
        vecs[10] = '{1'b1,1'b0,1'b0,1'b0, 24'h104, 24'h30, 4,0, 1'b0,1'b0,1'b0, 24'h0};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0, 24'h105, 24'h30, 5,0, 1'b0,1'b0,1'b0, 24'h0};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b1, 24'h0,   24'h30, 0,5, 1'b1,1'b1,1'b0, 24'h0};
        vecs[13] = '{1'b0,1'b0,1'b1,1'b0, 24'h0,   24'h30, 0,4, 1'b1,1'b0,1'b1, 24'h101};
        vecs[14] = '{1'b0,1'b0,1'b1,1'b0, 24'h0,   24'h30, 0,3, 1'b1,1'b0,1'b1, 24'h102};
        vecs[15] = '{1'b0,1'b0,1'b1,1'b0, 24'h0,   24'h30, 0,2, 1'b1,1'b0,1'b1, 24'h103};
        vecs[16] = '{1'b0,1'b0,1'b1,1'b0, 24'h0,   24'h30, 0,1, 1'b1,1'b0,1'b1, 24'h104};
        vecs[17] = '{1'b0,1'b0,1'b1,1'b0, 24'h0,   24'h30, 0,0, 1'b1,1'b0,1'b1, 24'h105};
        vecs[18] = '{1'b0,1'b0,1'b0,1'b0, 24'h0,   24'h30, 0,0, 1'b1,1'b0,1'b0, 24'h105};

        // ---- reset state ----
        do_reset();
        check_reset_state("reset");

        // ---- table ----
        for (int i = 0; i < 19; i++) begin
            cmp_wr = vecs[i].wr; cmp_rd = vecs[i].rd; out_rd = vecs[i].ord;
            swap_req = vecs[i].swp; cmp_din = vecs[i].din;
            cycle();
            $display("vec %0d: wr=%0d rd=%0d ord=%0d swp=%0d din=%0h -> cmp_dout=%0h cnt=%0d/%0d sel=%0d ack=%0d ov=%0d out_dout=%0h",
                     i, cmp_wr, cmp_rd, out_rd, swap_req, cmp_din, cmp_dout, cmp_count, out_count,
                     bank_sel, swap_ack, out_valid, out_dout);
            check("vec cmp_dout",  32'(cmp_dout),  32'(vecs[i].e_cdout));
            check("vec cmp_count", 32'(cmp_count), 32'(vecs[i].e_ccnt));
            check("vec out_count", 32'(out_count), 32'(vecs[i].e_ocnt));
            check("vec bank_sel",  32'(bank_sel),  32'(vecs[i].e_sel));
            check("vec swap_ack",  32'(swap_ack),  32'(vecs[i].e_ack));
            check("vec out_valid", 32'(out_valid), 32'(vecs[i].e_ov));
            check("vec out_dout",  32'(out_dout),  32'(vecs[i].e_odout));
        end
        idle_inputs();
        check("table cmp_empty", 32'(cmp_empty), 32'd1);

        // ---- full boundary, ignored push, accumulate at full ----
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cmp_wr = 1; cmp_din = DW'(i + 1);
            cycle();
        end
        $display("fill: cmp_count=%0d cmp_full=%0d", cmp_count, cmp_full);
        check("fill cmp_full",  32'(cmp_full),  32'd1);
        check("fill cmp_count", 32'(cmp_count), 32'(DEPTH));
        cmp_din = 24'hBAD;
        cycle();
        $display("push at full: cmp_count=%0d", cmp_count);
        check("overflow cmp_count", 32'(cmp_count), 32'(DEPTH));
`ifdef ACCFIFO_ERR_CHECK_EN
        check("overflow err", 32'(err), 32'd1);
`endif
        cmp_rd = 1; cmp_din = 24'h777;
        cycle();
        $display("rmw at full: cmp_count=%0d cmp_dout=%0h", cmp_count, cmp_dout);
        check("rmw full cmp_count", 32'(cmp_count), 32'(DEPTH));
        check("rmw full cmp_dout",  32'(cmp_dout),  32'd1);
        cmp_wr = 0;
        for (int i = 0; i < DEPTH; i++) begin
            cycle();
            check("drain cmp_dout", 32'(cmp_dout), (i < DEPTH - 1) ? 32'(i + 2) : 32'h777);
        end
        idle_inputs();
        $display("drain: cmp_count=%0d cmp_empty=%0d", cmp_count, cmp_empty);
        check("drain cmp_empty", 32'(cmp_empty), 32'd1);

        // ---- deferred swap through PENDING ----
        do_reset();
        cmp_wr = 1; cmp_din = 24'hA1; cycle();
        cmp_din = 24'hA2; cycle();
        cmp_wr = 0; swap_req = 1; cycle();
        check("swap1 ack", 32'(swap_ack), 32'd1);
        check("swap1 sel", 32'(bank_sel), 32'd1);
        check("swap1 ocnt", 32'(out_count), 32'd2);
        swap_req = 0;
        for (int i = 0; i < 3; i++) begin
            cmp_wr = 1; cmp_din = DW'(24'hB1 + i); cycle();
        end
        cmp_wr = 0; swap_req = 1; cycle();
        $display("swap req with out_count=%0d: ack=%0d sel=%0d", out_count, swap_ack, bank_sel);
        check("pend ack", 32'(swap_ack), 32'd0);
        check("pend sel", 32'(bank_sel), 32'd1);
        swap_req = 0; out_rd = 1; cycle();
        check("pend pop1 odout", 32'(out_dout), 32'hA1);
        check("pend pop1 ack",   32'(swap_ack), 32'd0);
        cycle();
        check("pend pop2 odout", 32'(out_dout), 32'hA2);
        check("pend pop2 ocnt",  32'(out_count), 32'd0);
        check("pend pop2 ack",   32'(swap_ack), 32'd0);
        out_rd = 0; cycle();
        $display("deferred swap: ack=%0d sel=%0d out_count=%0d", swap_ack, bank_sel, out_count);
        check("pend swap ack",  32'(swap_ack), 32'd1);
        check("pend swap sel",  32'(bank_sel), 32'd0);
        check("pend swap ocnt", 32'(out_count), 32'd3);
        check("pend swap ccnt", 32'(cmp_count), 32'd0);
        cycle();
        check("pend ack drop", 32'(swap_ack), 32'd0);
        out_rd = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("post swap odout", 32'(out_dout), 32'(24'hB1 + i));
        end
        idle_inputs();

        // ---- randomized run with mid-stream async reset ----
        do_reset();
        for (int i = 0; i < 460; i++) begin
            if (i == 32) begin
                rst = 1;
                #1;
                $display("async reset at cycle %0d", i);
                check_reset_state("mid reset");
                idle_inputs();
                cycle();
                rst = 0;
                model_reset();
            end else begin
                cmp_wr   = ($urandom_range(99) < ((i < 200) ? 75 : 40));
                cmp_rd   = ($urandom_range(99) < 35);
                out_rd   = ($urandom_range(99) < 30);
                swap_req = ($urandom_range(99) < 8);
                cmp_din  = DW'($urandom);
                model_step();
                cycle();
                compare_model();
            end
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
